// File: rtl/nvdla_axil2apb_bridge.sv
// AXI4-Lite slave to APB3 master bridge feeding the NVDLA CSB stage.
// One APB transfer in flight; a pready timeout aborts stalled accesses.
module nvdla_axil2apb_bridge #(
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 9
) (
  input  logic        pclk,
  input  logic        prstn,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready
);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    WRSP,
    RRSP
  } state_t;

  state_t state;
  state_t state_nx;

  logic             last_rd;
  logic [CNT_W-1:0] cnt;
  logic             wr_cand;
  logic             rd_cand;
  logic             wr_gnt;
  logic             rd_gnt;
  logic             strb_ok;
  logic             tmo;
  logic             done;

  // Round-robin: on contention the direction not served last wins.
  always_comb begin
    wr_cand = awvalid & wvalid;
    rd_cand = arvalid;
    wr_gnt  = wr_cand & (~rd_cand | last_rd);
    rd_gnt  = rd_cand & (~wr_cand | ~last_rd);
    strb_ok = (wstrb == 4'hF);
    tmo     = ~pready & (cnt == CNT_W'(TIMEOUT_CYC - 1));
    done    = (state == ACCESS) & (pready | tmo);
  end

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    awready  = 1'b0;
    wready   = 1'b0;
    arready  = 1'b0;
    psel     = 1'b0;
    penable  = 1'b0;
    bvalid   = 1'b0;
    rvalid   = 1'b0;
    unique case (state)
      IDLE: begin
        awready = wr_gnt;
        wready  = wr_gnt;
        arready = rd_gnt;
        if (wr_gnt) begin
          state_nx = strb_ok ? SETUP : WRSP;
        end else if (rd_gnt) begin
          state_nx = SETUP;
        end
      end
      SETUP: begin
        psel     = 1'b1;
        state_nx = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready | tmo) begin
          state_nx = pwrite ? WRSP : RRSP;
        end
      end
      WRSP: begin
        bvalid = 1'b1;
        if (bready) begin
          state_nx = IDLE;
        end
      end
      RRSP: begin
        rvalid = 1'b1;
        if (rready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      last_rd <= 1'b1;
      paddr   <= '0;
      pwdata  <= '0;
      pwrite  <= 1'b0;
      rdata   <= '0;
      bresp   <= OKAY;
      rresp   <= OKAY;
      cnt     <= '0;
    end else begin
      if (awready) begin
        paddr   <= awaddr & 32'hFFFF_FFFC;
        pwdata  <= wdata;
        pwrite  <= 1'b1;
        last_rd <= 1'b0;
        bresp   <= strb_ok ? OKAY : SLVERR;
      end else if (arready) begin
        paddr   <= araddr & 32'hFFFF_FFFC;
        pwrite  <= 1'b0;
        last_rd <= 1'b1;
      end
      if (state == SETUP) begin
        cnt <= '0;
      end else if (state == ACCESS && !pready) begin
        cnt <= cnt + 1'b1;
      end
      // A timed-out read returns zero data with SLVERR.
      if (done) begin
        if (pwrite) begin
          bresp <= pready ? OKAY : SLVERR;
        end else begin
          rdata <= pready ? prdata : 32'h0;
          rresp <= pready ? OKAY : SLVERR;
        end
      end
    end
  end

endmodule

// File: tb/tb_nvdla_axil2apb_bridge.sv
// Randomized bench for the AXI-Lite to APB bridge with a
// transaction-level reference model and APB slave responder.
module tb_nvdla_axil2apb_bridge;

  localparam int TO = 256;

  logic        pclk = 1'b0;
  logic        prstn = 1'b0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] awaddr = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [1:0]  bresp;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] araddr = '0;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;

  nvdla_axil2apb_bridge #(
    .TIMEOUT_CYC(TO),
    .CNT_W(9)
  ) dut (
    .pclk(pclk),
    .prstn(prstn),
    .awvalid(awvalid),
    .awready(awready),
    .awaddr(awaddr),
    .wvalid(wvalid),
    .wready(wready),
    .wdata(wdata),
    .wstrb(wstrb),
    .bvalid(bvalid),
    .bready(bready),
    .bresp(bresp),
    .arvalid(arvalid),
    .arready(arready),
    .araddr(araddr),
    .rvalid(rvalid),
    .rready(rready),
    .rdata(rdata),
    .rresp(rresp),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .paddr(paddr),
    .pwdata(pwdata),
    .prdata(prdata),
    .pready(pready)
  );

  always #5 pclk = ~pclk;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  bit          m_last_rd = 1'b1;
  bit          wpend = 1'b0;
  bit          rpend = 1'b0;
  logic [31:0] w_a, w_d, r_a;
  logic [3:0]  w_s;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_ctl"},
        {psel, penable, pwrite, bvalid, rvalid, awready, wready, arready}, 0);
    chk({tag, "_paddr"}, paddr, 0);
    chk({tag, "_pwdata"}, pwdata, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_resp"}, {bresp, rresp}, 0);
  endtask

  task automatic do_reset();
    prstn = 1'b0;
    awvalid = 0; wvalid = 0; arvalid = 0;
    bready = 0; rready = 0; pready = 0;
    m_last_rd = 1'b1;
    wpend = 0; rpend = 0;
    #1;
    chk_idle_outs("reset");
    @(negedge pclk);
    prstn = 1'b1;
    @(negedge pclk);
  endtask

  // Entered at the negedge after the address handshake; leaves at the
  // negedge where the response must be visible.
  task automatic apb_access(input bit is_wr, input logic [31:0] addr,
                            input logic [31:0] wd, input int waits,
                            input logic [31:0] prd);
    logic [31:0] ea;
    int          k;
    bit          done;
    bit          st;
    bit          tmo;
    ea = {addr[31:2], 2'b00};
    tmo = (waits >= TO);
    chk("setup_phase", {psel, penable}, 2'b10);
    chk("setup_paddr", paddr, ea);
    chk("setup_pwrite", pwrite, is_wr);
    if (is_wr) chk("setup_pwdata", pwdata, wd);
    chk("busy_ready", {awready, wready, arready}, 0);
    @(posedge pclk);
    @(negedge pclk);
    k = 0;
    done = 0;
    st = 1;
    while (!done) begin
      if (!(psel && penable && paddr == ea && pwrite == is_wr &&
            !bvalid && !rvalid)) st = 0;
      if (is_wr && pwdata != wd) st = 0;
      pready = (k == waits);
      prdata = (k == waits) ? prd : $urandom;
      @(posedge pclk);
      @(negedge pclk);
      pready = 0;
      done = (k == waits) || (k == TO - 1);
      k++;
    end
    chk("access_stable", st, 1);
    chk("access_end", {psel, penable}, 0);
    if (is_wr) begin
      chk("bvalid", {bvalid, rvalid}, 2'b10);
      chk("bresp", bresp, tmo ? 2'b10 : 2'b00);
    end else begin
      chk("rvalid", {bvalid, rvalid}, 2'b01);
      chk("rresp", rresp, tmo ? 2'b10 : 2'b00);
      chk("rdata", rdata, tmo ? 32'h0 : prd);
    end
  endtask

  task automatic resp_hs(input bit is_wr, input logic [1:0] er,
                         input logic [31:0] erd);
    int hold;
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      @(posedge pclk);
      @(negedge pclk);
      if (is_wr) begin
        chk("bhold", {bvalid, bresp}, {1'b1, er});
      end else begin
        chk("rhold", {rvalid, rresp}, {1'b1, er});
        chk("rhold_data", rdata, erd);
      end
    end
    if (is_wr) bready = 1; else rready = 1;
    @(posedge pclk);
    @(negedge pclk);
    bready = 0;
    rready = 0;
    chk("resp_done", {bvalid, rvalid, psel}, 0);
  endtask

  task automatic serve(input int ww, input int rw, input logic [31:0] rprd);
    bit gw, gr;
    while (wpend || rpend) begin
      awvalid = wpend; wvalid = wpend;
      awaddr = w_a; wdata = w_d; wstrb = w_s;
      arvalid = rpend; araddr = r_a;
      gw = wpend && (!rpend || m_last_rd);
      gr = rpend && !gw;
      #1;
      chk("grant", {awready, wready, arready}, {gw, gw, gr});
      @(posedge pclk);
      @(negedge pclk);
      if (gw) begin
        awvalid = 0; wvalid = 0; wpend = 0; m_last_rd = 0;
        if (w_s != 4'hF) begin
          chk("rej_nopsel", {psel, penable}, 0);
          chk("rej_bvalid", {bvalid, bresp}, 3'b110);
          resp_hs(1, 2'b10, 0);
        end else begin
          apb_access(1, w_a, w_d, ww, 0);
          resp_hs(1, (ww >= TO) ? 2'b10 : 2'b00, 0);
        end
      end else begin
        arvalid = 0; rpend = 0; m_last_rd = 1;
        apb_access(0, r_a, 0, rw, rprd);
        resp_hs(0, (rw >= TO) ? 2'b10 : 2'b00, (rw >= TO) ? 32'h0 : rprd);
      end
    end
  endtask

  function automatic int pick_waits();
    return ($urandom_range(0, 9) == 0) ? TO + 3 : $urandom_range(0, 6);
  endfunction

  initial begin
    do_reset();

    // single write, zero wait
    wpend = 1; w_a = 32'h0000_7004; w_d = 32'hDEAD_BEEF; w_s = 4'hF;
    serve(0, 0, 0);

    // read with five wait states
    rpend = 1; r_a = 32'h0000_1000;
    serve(0, 5, 32'h1234_5678);

    // contention twice after reset
    do_reset();
    wpend = 1; rpend = 1;
    w_a = 32'h0000_2008; w_d = 32'hA5A5_0001; w_s = 4'hF;
    r_a = 32'h0000_300C;
    serve(1, 2, 32'h0BAD_F00D);
    wpend = 1; rpend = 1;
    w_a = 32'h0000_2010; w_d = 32'h5A5A_0002;
    r_a = 32'h0000_3013;
    serve(0, 0, 32'hCAFE_0003);

    // partial strobe rejected
    wpend = 1; w_a = 32'h0000_4000; w_d = 32'h1111_2222; w_s = 4'h3;
    serve(0, 0, 0);

    // read timeout then a normal read
    rpend = 1; r_a = 32'h0000_5000;
    serve(0, TO + 10, 32'hFFFF_FFFF);
    rpend = 1; r_a = 32'h0000_5004;
    serve(0, 1, 32'h7777_8888);

    // reset in the middle of an access
    arvalid = 1; araddr = 32'h0000_6000;
    @(posedge pclk);
    @(negedge pclk);
    arvalid = 0;
    @(posedge pclk);
    @(negedge pclk);
    chk("mid_access", {psel, penable}, 2'b11);
    #2;
    prstn = 0;
    #1;
    chk_idle_outs("async_rst");
    @(negedge pclk);
    prstn = 1;
    m_last_rd = 1;
    @(negedge pclk);
    rpend = 1; r_a = 32'h0000_6004;
    serve(0, 2, 32'h0246_8ACE);

    // randomized mix
    repeat (40) begin
      wpend = $urandom_range(0, 1);
      rpend = $urandom_range(0, 1);
      if (!wpend && !rpend) rpend = 1;
      w_a = $urandom; w_d = $urandom; r_a = $urandom;
      w_s = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
      serve(pick_waits(), pick_waits(), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
